stopwatch_btn_cmd: RTL and testbench

Button command generator for the stopwatch control path. It takes three raw, asynchronous, bouncing push-button levels and turns each clean press into a single-cycle command pulse. The pulses are `start`, `stop` and `reset`, and they feed the stopwatch control FSM's command inputs directly. The block guarantees that at most one command is asserted in any cycle.

---
 rtl/stopwatch_btn_cmd.sv | 146 ++++++++++++++
 tb/tb_stopwatch_btn_cmd.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_btn_cmd.sv
`timescale 1ns/1ps
// Purpose: debounces three raw push-buttons into one-cycle start/stop/reset commands, at most one per cycle.
// Latency: a command is high in the cycle after edge DEBOUNCE_CYCLES+1, where edge 0 is the first edge to sample the new level.
// Backpressure: none; a press that loses arbitration on its accept edge is dropped, not queued.
// Option: define STOPWATCH_LONGPRESS_RESET_EN to raise one reset after stop is held LONG_CYCLES edges.
module stopwatch_btn_cmd #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES     = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start,
  input  logic btn_stop,
  input  logic btn_reset,
  output logic start,
  output logic stop,
  output logic reset
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam int            CH_START = 0;
  localparam int            CH_STOP  = 1;
  localparam int            CH_RESET = 2;

  // Reject parameter values the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 2..65535");
  end
  if (LONG_CYCLES == 0) begin : g_bad_long
    $error("LONG_CYCLES must be at least 1");
  end

  // Per-channel state, bit/element index = CH_* above.
  logic [2:0]    btn_raw;
  logic [2:0]    s1_q, s1_d;
  logic [2:0]    s2_q, s2_d;
  logic [2:0]    lvl_q, lvl_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    press_evt;

  logic          long_evt;
  logic          reset_evt;
  logic          start_q, start_d;
  logic          stop_q, stop_d;
  logic          reset_q, reset_d;

  assign btn_raw = {btn_reset, btn_stop, btn_start};

  // Synchronize each button and debounce it against its accepted level.
  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    lvl_d     = lvl_q;
    press_evt = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        // Accept edge: only a 0->1 acceptance counts as a press.
        lvl_d[i]     = s2_q[i];
        cnt_d[i]     = '0;
        press_evt[i] = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      lvl_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      lvl_q <= lvl_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef STOPWATCH_LONGPRESS_RESET_EN
  localparam int unsigned   HW       = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_q, hold_d;

  // Count edges with stop accepted high; fire once on reaching LONG_CYCLES, then hold saturated.
  always_comb begin
    hold_d   = hold_q;
    long_evt = 1'b0;
    if (!lvl_q[CH_STOP]) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d   = hold_q + HW'(1);
      long_evt = (hold_d == HOLD_MAX);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign long_evt = 1'b0;
`endif

  // Arbitrate same-edge events: reset beats stop beats start.
  always_comb begin
    reset_evt = press_evt[CH_RESET] | long_evt;
    reset_d   = reset_evt;
    stop_d    = !reset_evt && press_evt[CH_STOP];
    start_d   = !reset_evt && !press_evt[CH_STOP] && press_evt[CH_START];
  end

  // Registered single-cycle command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      start_q <= start_d;
      stop_q  <= stop_d;
      reset_q <= reset_d;
    end
  end

  assign start = start_q;
  assign stop  = stop_q;
  assign reset = reset_q;

endmodule

// File: tb/tb_stopwatch_btn_cmd.sv
`timescale 1ns/1ps
module tb_stopwatch_btn_cmd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_start = 1'b0;
  logic btn_stop = 1'b0;
  logic btn_reset = 1'b0;
  logic start, stop, reset;

  int errors = 0;
  int checks = 0;

  // Pulse counts and first-high sample index per output for the last watch window.
  int cs, cp, cr, fs, fp, fr;
  int acc;
  int act_first;

  stopwatch_btn_cmd #(
    .DEBOUNCE_CYCLES(16),
    .LONG_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_start(btn_start),
    .btn_stop(btn_stop),
    .btn_reset(btn_reset),
    .start(start),
    .stop(stop),
    .reset(reset)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  b_start;
    logic  b_stop;
    logic  b_reset;
    int    exp_start;
    int    exp_stop;
    int    exp_reset;
    int    exp_first;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sample n cycles; sample k reflects outputs right after edge k, where edge 0 is
  // the first posedge after the caller's last drive (drives happen at negedges).
  task automatic watch(input int n);
    cs = 0; cp = 0; cr = 0;
    fs = -1; fp = -1; fr = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (start !== 1'b0) begin if (cs == 0) fs = k; cs++; end
      if (stop  !== 1'b0) begin if (cp == 0) fp = k; cp++; end
      if (reset !== 1'b0) begin if (cr == 0) fr = k; cr++; end
    end
  endtask

  task automatic release_all(input string name);
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_reset = 1'b0;
    watch(40);
    check({name, " release quiet"}, cs + cp + cr, 0);
  endtask

  initial begin
    vecs[0] = '{"start only",  1'b1, 1'b0, 1'b0, 1, 0, 0, 17};
    vecs[1] = '{"stop only",   1'b0, 1'b1, 1'b0, 0, 1, 0, 17};
    vecs[2] = '{"reset only",  1'b0, 1'b0, 1'b1, 0, 0, 1, 17};
    vecs[3] = '{"all three",   1'b1, 1'b1, 1'b1, 0, 0, 1, 17};
    vecs[4] = '{"start+stop",  1'b1, 1'b1, 1'b0, 0, 1, 0, 17};
    vecs[5] = '{"start+reset", 1'b1, 1'b0, 1'b1, 0, 0, 1, 17};
    vecs[6] = '{"stop+reset",  1'b0, 1'b1, 1'b1, 0, 0, 1, 17};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset outputs", int'({start, stop, reset}), 0);
    rst_n = 1'b1;
    watch(5);
    check("idle after reset", cs + cp + cr, 0);

    // Table: single and simultaneous presses held 40 cycles, then released
    for (int i = 0; i < 7; i++) begin
      btn_start = vecs[i].b_start;
      btn_stop  = vecs[i].b_stop;
      btn_reset = vecs[i].b_reset;
      watch(40);
      check({vecs[i].name, " start count"}, cs, vecs[i].exp_start);
      check({vecs[i].name, " stop count"},  cp, vecs[i].exp_stop);
      check({vecs[i].name, " reset count"}, cr, vecs[i].exp_reset);
      act_first = (vecs[i].exp_start != 0) ? fs : (vecs[i].exp_stop != 0) ? fp : fr;
      check({vecs[i].name, " pulse edge"}, act_first, vecs[i].exp_first);
      release_all(vecs[i].name);
    end

    // Bounce: 5-high/5-low excursions never reach the debounce threshold
    acc = 0;
    for (int p = 0; p < 10; p++) begin
      btn_stop = 1'b1;
      watch(5);
      acc += cs + cp + cr;
      btn_stop = 1'b0;
      watch(5);
      acc += cs + cp + cr;
    end
    watch(20);
    acc += cs + cp + cr;
    check("bounce no pulse", acc, 0);
    btn_stop = 1'b1;
    watch(40);
    check("bounce settle stop count", cp, 1);
    check("bounce settle stop edge", fp, 17);
    check("bounce settle others", cs + cr, 0);
    release_all("bounce");

    // Presses accepted on different edges each pulse
    btn_start = 1'b1;
    watch(5);
    check("stagger early quiet", cs + cp + cr, 0);
    btn_stop = 1'b1;
    watch(35);
    check("stagger start count", cs, 1);
    check("stagger start edge", fs, 12);
    check("stagger stop count", cp, 1);
    check("stagger stop edge", fp, 17);
    check("stagger reset count", cr, 0);
    release_all("stagger");

    // rst_n asserted mid-pulse drops the output without a clock edge
    btn_start = 1'b1;
    watch(17);
    check("pre-pulse quiet", cs + cp + cr, 0);
    @(posedge clk);
    @(negedge clk);
    check("pulse before rst_n", int'(start), 1);
    #1 rst_n = 1'b0;
    #1 check("async output drop", int'({start, stop, reset}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    watch(40);
    check("held over rst_n start count", cs, 1);
    check("held over rst_n start edge", fs, 17);
    check("held over rst_n others", cp + cr, 0);
    release_all("rst mid-pulse");

    // rst_n asserted at debounce count 10 while the button stays held
    btn_start = 1'b1;
    watch(11);
    check("mid-debounce quiet", cs + cp + cr, 0);
    rst_n = 1'b0;
    #1 check("mid-debounce rst outputs", int'({start, stop, reset}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    watch(40);
    check("mid-debounce restart count", cs, 1);
    check("mid-debounce restart edge", fs, 17);
    check("mid-debounce others", cp + cr, 0);
    release_all("rst mid-debounce");

    // Long hold of stop
    btn_stop = 1'b1;
    watch(200);
    check("long stop count", cp, 1);
    check("long stop edge", fp, 17);
    check("long start count", cs, 0);
`ifdef STOPWATCH_LONGPRESS_RESET_EN
    check("long reset count", cr, 1);
    check("long reset edge", fr, 81);
`else
    check("long reset count", cr, 0);
`endif
    release_all("long press");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
